sa_dma_stream_bridge: RTL and testbench
=======================================

Name: sa_dma_stream_bridge

Overview:
- DMA-side counterpart of the systolic array engine's start/DMA handshake.
- Answers the engine's read request (start_rd_wr=2'b10) by streaming exactly IN_WORDS words from an AXI4-Stream MM2S source onto DATA_IN / read_data_vld.
- Answers the engine's write request (start_rd_wr=2'b11) by capturing the engine's non-stallable OUT_WORDS-word DATA_OUT burst into a FIFO, then replaying it as an AXI4-Stream S2MM frame with back-pressure and TLAST.

Parameters:
- DW, 32, data width of both the engine and stream sides
- IN_WORDS, 32, words fed to the engine per read request
- OUT_WORDS, 64, words captured from the engine per write request
- CAP_LAT, 3, cycles from the write-request cycle to the first valid eng_data_out word
- FIFO_DEPTH, 64, output buffer depth; must be ≥ OUT_WORDS (elaboration assertion)

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- eng_start_rd_wr  in  2  engine request: 10 = read, 11 = write, others = none
- eng_read_data_vld  out  1  word valid toward the engine
- eng_data_in  out  DW  word toward the engine
- eng_data_out  in  DW  engine result word, valid in the capture window
- s_axis_tdata  in  DW  MM2S data
- s_axis_tvalid  in  1  MM2S valid
- s_axis_tready  out  1  MM2S ready
- s_axis_tlast  in  1  MM2S last
- m_axis_tdata  out  DW  S2MM data
- m_axis_tvalid  out  1  S2MM valid
- m_axis_tready  in  1  S2MM ready
- m_axis_tlast  out  1  S2MM last
- rd_busy  out  1  feed FSM not idle
- wr_busy  out  1  capture/drain FSM not idle
- err_sticky  out  3  [0] early s_axis_tlast, [1] missing s_axis_tlast, [2] capture overrun; cleared only by reset

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. Every output is 0 on reset, both FSMs go to IDLE, and all counters and the FIFO clear. Reset mid-operation aborts any partial transfer.
- Feed FSM, RD_IDLE -> RD_FEED -> RD_IDLE:
  - RD_IDLE to RD_FEED on eng_start_rd_wr==2'b10.
  - In RD_FEED: s_axis_tready=1 and in_cnt counts accepted beats.
  - eng_read_data_vld and eng_data_in are registered copies of each accepted beat, 1-cycle latency, no bubbles inserted.
  - Exits when in_cnt reaches IN_WORDS-1 on an accepted beat; s_axis_tready drops the next cycle.
  - In RD_IDLE, s_axis_tready=0.
- TLAST checks:
  - TLAST on a beat before IN_WORDS-1 sets err[0]; feeding continues and the count rules.
  - No TLAST on beat IN_WORDS-1 sets err[1].
- Request handling in RD_FEED: a repeated 2'b10 is ignored. A 2'b11 is handled by the write FSM independently.
- Write FSM, WR_IDLE -> WR_WAIT -> WR_CAP -> WR_DRAIN -> WR_IDLE:
  - WR_IDLE to WR_WAIT on eng_start_rd_wr==2'b11. A level held for several cycles counts as one request; edge-detect against the previous sample.
  - WR_WAIT counts CAP_LAT-1 cycles. The first capture occurs in the cycle that is request cycle + CAP_LAT.
  - WR_CAP pushes eng_data_out into the FIFO every cycle, unconditionally, for exactly OUT_WORDS cycles, then goes to WR_DRAIN.
- Draining:
  - m_axis_tvalid = FIFO not empty. Draining starts during WR_CAP (first word visible one cycle after its push).
  - Standard AXIS rule: data and last hold while tvalid && !tready.
  - m_axis_tlast is asserted on the OUT_WORDS-th popped word (out_cnt == OUT_WORDS-1).
  - WR_DRAIN to WR_IDLE on the pop carrying tlast.
- Overrun:
  - A new 2'b11 edge while wr_busy sets err[2] and is dropped.
  - A push into a full FIFO also sets err[2]; the word is discarded and the count still advances.
- Simultaneous events: a push and a pop in the same cycle keep occupancy unchanged, and the pop returns the oldest word.
- Busy flags: rd_busy is 1 in RD_FEED; wr_busy is 1 in any non-idle write state.

Decomposition:
- Package sa_dma_pkg:
  - rd_state_t {RD_IDLE, RD_FEED}
  - wr_state_t {WR_IDLE, WR_WAIT, WR_CAP, WR_DRAIN}
  - request codes REQ_RD=2'b10, REQ_WR=2'b11
  - error bit indices
- Sub-module sa_sync_fifo: DW x FIFO_DEPTH, first-word-fall-through, with full, empty and count outputs and async reset.

Test Plan:
- Read, basic: pulse 2'b10, source 32 beats 0x1000+i with tlast on beat 31 and no stalls -> eng_read_data_vld high exactly 32 cycles, data 0x1000..0x101F, each 1 cycle after acceptance; s_axis_tready low afterwards; err=0.
- Read, irregular source: source tvalid toggling 1,0,0,1…, tlast on beat 20 -> still 32 words delivered in order; err[0]=1, err[1]=1.
- Write, no back-pressure: hold 2'b11 for 2 cycles, drive eng_data_out = 0xA000+k starting at request+3, m_axis_tready=1 -> one frame of 64 beats 0xA000..0xA03F, tlast only on 0xA03F; err=0.
- Write, back-pressure: m_axis_tready low until 40 cycles after the request, then 1-of-3 -> all 64 words are captured, none lost, order kept, tlast on beat 64; wr_busy drops the cycle after the last handshake.
- Overlap: 2'b10 and 2'b11 issued in the same cycle -> both transfers complete correctly and concurrently. A second 2'b11 during drain -> err[2]=1 and exactly one frame is output.
- Reset mid-write: assert rstn=0 after 30 captures -> all outputs 0 immediately. After release, a new write request yields a clean 64-beat frame.

Source files
------------

// File: rtl/sa_dma_pkg.sv
// sa_dma_pkg: shared states, request codes and error bit positions for the DMA stream bridge
package sa_dma_pkg;
  typedef enum logic {RD_IDLE, RD_FEED} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_WAIT, WR_CAP, WR_DRAIN} wr_state_t;
  localparam logic [1:0] REQ_RD = 2'b10;
  localparam logic [1:0] REQ_WR = 2'b11;
  localparam int ERR_EARLY_LAST = 0;
  localparam int ERR_NO_LAST = 1;
  localparam int ERR_OVERRUN = 2;
endpackage

// File: rtl/sa_sync_fifo.sv
// sa_sync_fifo: first-word-fall-through synchronous FIFO with occupancy count
module sa_sync_fifo #(
  parameter int DW = 32,
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [DW-1:0]              din,
  input  logic                       pop,
  output logic [DW-1:0]              dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? (wr_ptr_q == AW'(DEPTH-1) ? '0 : wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = do_pop ? (rd_ptr_q == AW'(DEPTH-1) ? '0 : rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q] <= din;
endmodule

// File: rtl/sa_dma_stream_bridge.sv
// sa_dma_stream_bridge: feeds engine read bursts from MM2S and replays captured engine write bursts to S2MM
module sa_dma_stream_bridge
  import sa_dma_pkg::*;
#(
  parameter int DW = 32,
  parameter int IN_WORDS = 32,
  parameter int OUT_WORDS = 64,
  parameter int CAP_LAT = 3,
  parameter int FIFO_DEPTH = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [1:0]    eng_start_rd_wr,
  output logic          eng_read_data_vld,
  output logic [DW-1:0] eng_data_in,
  input  logic [DW-1:0] eng_data_out,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic          s_axis_tlast,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic          m_axis_tlast,
  output logic          rd_busy,
  output logic          wr_busy,
  output logic [2:0]    err_sticky
);
  localparam int IW = $clog2(IN_WORDS+1);
  localparam int OW = $clog2(OUT_WORDS+1);
  localparam int CW = $clog2(OUT_WORDS+CAP_LAT+1);
  localparam int FW = $clog2(FIFO_DEPTH+1);
  if (FIFO_DEPTH < OUT_WORDS) begin : g_depth_chk
    $error("FIFO_DEPTH must be at least OUT_WORDS");
  end
  rd_state_t rd_state_q, rd_state_d;
  wr_state_t wr_state_q, wr_state_d;
  logic [IW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic [2:0] err_q, err_d;
  logic req_wr_q, req_wr_d, vld_q, vld_d;
  logic [DW-1:0] din_q, din_d, fifo_dout;
  logic [FW-1:0] fifo_cnt;
  logic acc, in_last, wr_edge, push, pop, fifo_full, fifo_empty;
  assign s_axis_tready     = rd_state_q == RD_FEED;
  assign eng_read_data_vld = vld_q;
  assign eng_data_in       = din_q;
  assign m_axis_tvalid     = fifo_cnt != '0;
  assign m_axis_tdata      = fifo_empty ? '0 : fifo_dout;
  assign m_axis_tlast      = m_axis_tvalid && out_cnt_q == OW'(OUT_WORDS-1);
  assign rd_busy           = rd_state_q != RD_IDLE;
  assign wr_busy           = wr_state_q != WR_IDLE;
  assign err_sticky        = err_q;
  always_comb begin
    acc        = s_axis_tready && s_axis_tvalid;
    in_last    = in_cnt_q == IW'(IN_WORDS-1);
    req_wr_d   = eng_start_rd_wr == REQ_WR;
    wr_edge    = req_wr_d && !req_wr_q;
    push       = wr_state_q == WR_CAP;
    pop        = m_axis_tvalid && m_axis_tready;
    rd_state_d = rd_state_q == RD_IDLE && eng_start_rd_wr == REQ_RD ? RD_FEED :
                 acc && in_last ? RD_IDLE : rd_state_q;
    in_cnt_d   = acc ? (in_last ? '0 : in_cnt_q + IW'(1)) : in_cnt_q;
    vld_d      = acc;
    din_d      = acc ? s_axis_tdata : din_q;
    out_cnt_d  = pop ? (m_axis_tlast ? '0 : out_cnt_q + OW'(1)) : out_cnt_q;
    err_d      = err_q;
    err_d[ERR_EARLY_LAST] = err_q[ERR_EARLY_LAST] | (acc && !in_last && s_axis_tlast);
    err_d[ERR_NO_LAST]    = err_q[ERR_NO_LAST] | (acc && in_last && !s_axis_tlast);
    err_d[ERR_OVERRUN]    = err_q[ERR_OVERRUN] | (wr_edge && wr_busy) | (push && fifo_full);
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    // the engine burst cannot stall, so capture runs on a fixed cycle count
    case (wr_state_q)
      WR_IDLE: if (wr_edge) begin
        wr_state_d = CAP_LAT > 1 ? WR_WAIT : WR_CAP;
        wr_cnt_d   = '0;
      end
      WR_WAIT: begin
        wr_state_d = wr_cnt_q == CW'(CAP_LAT-2) ? WR_CAP : WR_WAIT;
        wr_cnt_d   = wr_cnt_q == CW'(CAP_LAT-2) ? '0 : wr_cnt_q + CW'(1);
      end
      WR_CAP: begin
        wr_state_d = wr_cnt_q == CW'(OUT_WORDS-1) ? WR_DRAIN : WR_CAP;
        wr_cnt_d   = wr_cnt_q == CW'(OUT_WORDS-1) ? '0 : wr_cnt_q + CW'(1);
      end
      default: wr_state_d = pop && m_axis_tlast ? WR_IDLE : WR_DRAIN;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      in_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      out_cnt_q  <= '0;
      err_q      <= '0;
      req_wr_q   <= 1'b0;
      vld_q      <= 1'b0;
      din_q      <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      in_cnt_q   <= in_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      out_cnt_q  <= out_cnt_d;
      err_q      <= err_d;
      req_wr_q   <= req_wr_d;
      vld_q      <= vld_d;
      din_q      <= din_d;
    end
  sa_sync_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push),
    .din  (eng_data_out),
    .pop  (pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_cnt)
  );
endmodule

// File: tb/tb_sa_dma_stream_bridge.sv
// tb_sa_dma_stream_bridge: table-driven read/write vectors plus overlap, overrun and reset sequences
module tb_sa_dma_stream_bridge;
  import sa_dma_pkg::*;
  localparam int DW = 32;
  localparam int IN_WORDS = 32;
  localparam int OUT_WORDS = 64;
  localparam int CAP_LAT = 3;
  localparam int FIFO_DEPTH = 64;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic [1:0] eng_start_rd_wr = 2'b00;
  logic eng_read_data_vld;
  logic [DW-1:0] eng_data_in;
  logic [DW-1:0] eng_data_out = '0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic s_axis_tvalid = 1'b0;
  logic s_axis_tready;
  logic s_axis_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic m_axis_tready = 1'b1;
  logic m_axis_tlast;
  logic rd_busy, wr_busy;
  logic [2:0] err_sticky;

  always #5 clk = ~clk;

  sa_dma_stream_bridge #(
    .DW(DW), .IN_WORDS(IN_WORDS), .OUT_WORDS(OUT_WORDS), .CAP_LAT(CAP_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .eng_start_rd_wr(eng_start_rd_wr),
    .eng_read_data_vld(eng_read_data_vld), .eng_data_in(eng_data_in), .eng_data_out(eng_data_out),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .rd_busy(rd_busy),
    .wr_busy(wr_busy), .err_sticky(err_sticky)
  );

  typedef struct {
    string name;
    bit is_wr;
    int last_beat;
    bit irregular;
    int hold;
    int bp;
    logic [2:0] exp_err;
  } vec_t;
  vec_t vecs[6];

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] wr_q[$];
  logic last_q[$];
  logic hs_prev = 1'b0;
  logic last_hs_prev = 1'b0;
  logic [DW-1:0] d_prev = '0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // every accepted source beat must reach the engine exactly one cycle later
  always @(negedge clk) begin
    if (!rstn) begin
      hs_prev = 1'b0;
      last_hs_prev = 1'b0;
    end else begin
      chk("rd_vld_latency", eng_read_data_vld, hs_prev);
      if (hs_prev) chk("rd_data_latency", eng_data_in, d_prev);
      if (eng_read_data_vld) rd_q.push_back(eng_data_in);
      if (last_hs_prev) chk("wr_busy_after_last", wr_busy, 0);
      if (m_axis_tvalid && m_axis_tready) begin
        wr_q.push_back(m_axis_tdata);
        last_q.push_back(m_axis_tlast);
        if (m_axis_tlast) chk("wr_busy_at_last", wr_busy, 1);
      end
      last_hs_prev = m_axis_tvalid && m_axis_tready && m_axis_tlast;
      hs_prev = s_axis_tvalid && s_axis_tready;
      d_prev = s_axis_tdata;
    end
  end

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("reset_outputs", {eng_read_data_vld, eng_data_in, s_axis_tready, m_axis_tdata, m_axis_tvalid,
                          m_axis_tlast, rd_busy, wr_busy, err_sticky}, '0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    rd_q.delete();
    wr_q.delete();
    last_q.delete();
  endtask

  task automatic pulse(input logic [1:0] code);
    eng_start_rd_wr = code;
    @(posedge clk);
    #1 eng_start_rd_wr = 2'b00;
  endtask

  task automatic feed(input int last_beat, input bit irregular);
    int i;
    logic hs;
    i = 0;
    for (int c = 0; c < 400 && i < IN_WORDS; c++) begin
      s_axis_tvalid = irregular ? (c % 3 == 0) : 1'b1;
      s_axis_tdata = 32'(32'h1000 + i);
      s_axis_tlast = i == last_beat;
      @(negedge clk);
      hs = s_axis_tvalid && s_axis_tready;
      @(posedge clk);
      #1;
      if (hs) i++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    chk("feed_beats", i, IN_WORDS);
  endtask

  task automatic eng_write(input int hold);
    eng_start_rd_wr = REQ_WR;
    fork
      begin
        repeat (hold) @(posedge clk);
        #1 eng_start_rd_wr = 2'b00;
      end
      begin
        repeat (CAP_LAT) @(posedge clk);
        for (int k = 0; k < OUT_WORDS; k++) begin
          #1 eng_data_out = 32'(32'hA000 + k);
          @(posedge clk);
        end
        #1 eng_data_out = '0;
      end
    join
  endtask

  task automatic drive_ready(input int mode);
    for (int c = 0; c < 2000; c++) begin
      m_axis_tready = mode == 0 ? 1'b1 : mode == 1 ? (c >= 40 && c % 3 == 0) : (c % 2 == 0);
      @(posedge clk);
      #1;
      if (c > 5 && !wr_busy) break;
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 1000 && (rd_busy || wr_busy); c++) begin
      @(posedge clk);
      #1;
    end
    chk("idle", {rd_busy, wr_busy}, 2'b00);
  endtask

  task automatic check_read(input string tag);
    chk({tag, "_rd_words"}, rd_q.size(), IN_WORDS);
    for (int i = 0; i < IN_WORDS && i < rd_q.size(); i++)
      chk({tag, "_rd_data"}, rd_q[i], 32'(32'h1000 + i));
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_wr_beats"}, wr_q.size(), OUT_WORDS);
    for (int k = 0; k < OUT_WORDS && k < wr_q.size(); k++) begin
      chk({tag, "_wr_data"}, wr_q[k], 32'(32'hA000 + k));
      chk({tag, "_wr_last"}, last_q[k], k == OUT_WORDS - 1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{name: "rd_basic",    is_wr: 1'b0, last_beat: 31, irregular: 1'b0, hold: 0, bp: 0, exp_err: 3'b000};
    vecs[1] = '{name: "rd_irregular", is_wr: 1'b0, last_beat: 20, irregular: 1'b1, hold: 0, bp: 0, exp_err: 3'b011};
    vecs[2] = '{name: "rd_no_last",  is_wr: 1'b0, last_beat: -1, irregular: 1'b0, hold: 0, bp: 0, exp_err: 3'b010};
    vecs[3] = '{name: "wr_free",     is_wr: 1'b1, last_beat: 0,  irregular: 1'b0, hold: 2, bp: 0, exp_err: 3'b000};
    vecs[4] = '{name: "wr_bp",       is_wr: 1'b1, last_beat: 0,  irregular: 1'b0, hold: 1, bp: 1, exp_err: 3'b000};
    vecs[5] = '{name: "wr_alt",      is_wr: 1'b1, last_beat: 0,  irregular: 1'b0, hold: 5, bp: 2, exp_err: 3'b000};
    #2;
    foreach (vecs[v]) begin
      do_reset();
      m_axis_tready = 1'b1;
      if (!vecs[v].is_wr) begin
        pulse(REQ_RD);
        feed(vecs[v].last_beat, vecs[v].irregular);
      end else begin
        fork
          eng_write(vecs[v].hold);
          drive_ready(vecs[v].bp);
        join
      end
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      chk({vecs[v].name, "_tready_low"}, s_axis_tready, 0);
      chk({vecs[v].name, "_err"}, err_sticky, vecs[v].exp_err);
      if (vecs[v].is_wr) check_frame(vecs[v].name);
      else check_read(vecs[v].name);
    end

    do_reset();
    m_axis_tready = 1'b1;
    pulse(REQ_RD);
    fork
      feed(31, 1'b0);
      eng_write(1);
    join
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check_read("overlap");
    check_frame("overlap");
    chk("overlap_err", err_sticky, 3'b000);

    do_reset();
    m_axis_tready = 1'b0;
    eng_write(2);
    chk("drop_pending", {wr_busy, m_axis_tvalid}, 2'b11);
    pulse(REQ_WR);
    chk("drop_err", err_sticky, 3'b100);
    m_axis_tready = 1'b1;
    wait_idle();
    repeat (10) @(posedge clk);
    #1;
    check_frame("drop");
    chk("drop_idle", wr_busy, 0);

    do_reset();
    m_axis_tready = 1'b0;
    eng_start_rd_wr = REQ_WR;
    @(posedge clk);
    #1 eng_start_rd_wr = 2'b00;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 30; k++) begin
      #1 eng_data_out = 32'(32'hA000 + k);
      @(posedge clk);
    end
    #1;
    chk("pre_reset_busy", {wr_busy, m_axis_tvalid}, 2'b11);
    do_reset();
    eng_data_out = '0;
    fork
      eng_write(1);
      drive_ready(0);
    join
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check_frame("post_reset");
    chk("post_reset_err", err_sticky, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
